xor3_sweep_ctrl: RTL and testbench
==================================

// Module: xor3_sweep_ctrl
// PURPOSE
//   Self-test sequencer for the 3-input XOR gate (a,b,c -> y).
//   On start, drives the gate through all 2**N_IN input combinations in ascending order.
//   Waits SETTLE cycles per vector, samples y, and compares it with the EXPECT truth table.
//   Reports done/pass, the mismatch count and the first failing vector.
//   Sits beside the gate in lab builds; replaces a hand-written stimulus sequence with hardware sweep plus check.
// PARAMETERS
//   N_IN    3             gate input count; vector index width
//   SETTLE  2             wait cycles per vector before the sample cycle; must be >= 1
//   EXPECT  8'b1001_0110  expected y per vector; bit i = y for {a,b,c}=i (odd parity)
// PORTS
//   clk             in   1        rising-edge clock
//   rst             in   1        synchronous, active-high reset
//   start           in   1        begin sweep; sampled only in IDLE
//   gate_y          in   1        gate output under test
//   gate_in         out  N_IN     registered gate inputs {a,b,c} (MSB = a)
//   busy            out  1        sweep in progress
//   done            out  1        one-cycle pulse at sweep end
//   pass            out  1        last sweep had zero mismatches; held until next start
//   err_count       out  N_IN+1   mismatches in last/current sweep (max 2**N_IN, no overflow)
//   fail_valid      out  1        at least one mismatch recorded this sweep
//   first_fail_idx  out  N_IN     index of first mismatching vector; valid when fail_valid=1
// BEHAVIOUR
//   - Reset (rst=1 at posedge): state=IDLE; every output = 0.
//     Reset mid-sweep aborts the sweep immediately; no done pulse is produced.
//   - States: IDLE, WAIT, SAMPLE. All outputs are registered.
//   - IDLE, start=1:
//     -> WAIT; gate_in<=0; cnt<=0; busy<=1.
//     -> err_count<=0; fail_valid<=0; first_fail_idx<=0; pass<=0.
//   - IDLE, start=0: hold; pass, err_count and fail info keep their last sweep results.
//   - WAIT: cnt increments each cycle; when cnt==SETTLE-1 -> SAMPLE.
//   - SAMPLE, on the compare edge:
//     - mismatch = gate_y ^ EXPECT[gate_in].
//     - mismatch -> err_count+1; if fail_valid==0, set first_fail_idx<=gate_in and fail_valid<=1.
//     - gate_in < 2**N_IN-1 -> gate_in+1, cnt<=0, -> WAIT.
//     - gate_in == last -> IDLE; busy<=0; done<=1; pass <= (final err_count==0).
//       gate_in holds the last vector (no wrap).
//   - gate_y is sampled SETTLE+1 cycles after the gate_in change; each vector takes SETTLE+1 cycles.
//   - Latency: start edge to done-high edge = 2**N_IN*(SETTLE+1) cycles (24 at defaults).
//   - done is high for exactly one cycle and is cleared on the next edge.
//   - start is ignored while busy=1; no queuing.
//   - start=1 in the done cycle (state already IDLE) is accepted: a new sweep begins and results clear.
//   - rst wins over start on the same edge.
//   - gate_y is only observed in SAMPLE; X/glitches at other times are ignored.
// TESTING
//   1. Golden XOR, SETTLE=2, start pulse
//      -> gate_in steps 0..7, each held 3 cycles; done 24 cycles after start.
//      -> pass=1, err_count=0, fail_valid=0.
//   2. Gate model stuck-at-0
//      -> err_count=4 (vectors 1,2,4,7), first_fail_idx=1, fail_valid=1, pass=0.
//   3. Inverted gate (XNOR)
//      -> err_count=8, first_fail_idx=0, pass=0; err_count reaches 8 without wrap.
//   4. start re-asserted while busy at vector 3
//      -> ignored; sweep completes with a single done pulse at cycle 24.
//   5. rst asserted during vector 3
//      -> next cycle all outputs 0, state IDLE, no done pulse.
//      -> a later start on the golden gate gives pass=1 after 24 cycles.
//   6. start held high continuously with a golden gate
//      -> back-to-back sweeps, done every 25 cycles (24 + 1 IDLE cycle).
//      -> err_count cleared at each sweep start; pass=1 after each done.

Source files
------------

// File: rtl/xor3_sweep_ctrl.sv
// Self-test sequencer for a 3-input XOR gate: sweeps every input vector in
// ascending order, waits SETTLE cycles per vector, samples y and checks it against EXPECT.
module xor3_sweep_ctrl #(
  parameter int                    N_IN   = 3,
  parameter int                    SETTLE = 2,
  parameter logic [2**N_IN-1:0]    EXPECT = 8'b1001_0110
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            gate_y,
  output logic [N_IN-1:0] gate_in,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            fail_valid,
  output logic [N_IN-1:0] first_fail_idx
);
  localparam int EW = N_IN + 1;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [N_IN-1:0] LAST = '1;

  typedef enum logic [1:0] {IDLE, WAIT, SAMPLE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            mismatch;
  logic [EW-1:0]   err_nxt;

  // err_count tops out at 2**N_IN, which EW bits hold without wrapping
  always_comb begin
    mismatch = gate_y ^ EXPECT[gate_in];
    err_nxt  = err_count + EW'(mismatch);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      gate_in        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      fail_valid     <= 1'b0;
      first_fail_idx <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state          <= WAIT;
            gate_in        <= '0;
            cnt            <= '0;
            busy           <= 1'b1;
            err_count      <= '0;
            fail_valid     <= 1'b0;
            first_fail_idx <= '0;
            pass           <= 1'b0;
          end
        end
        WAIT: begin
          if (cnt == CW'(SETTLE - 1)) state <= SAMPLE;
          else                        cnt   <= cnt + 1'b1;
        end
        SAMPLE: begin
          err_count <= err_nxt;
          if (mismatch && !fail_valid) begin
            fail_valid     <= 1'b1;
            first_fail_idx <= gate_in;
          end
          if (gate_in != LAST) begin
            gate_in <= gate_in + 1'b1;
            cnt     <= '0;
            state   <= WAIT;
          end else begin
            // last vector stays on gate_in after the sweep
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_nxt == '0);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_xor3_sweep_ctrl.sv
// Bench for xor3_sweep_ctrl: gate model with selectable faults, expected sweep
// results queued at start and compared when done pulses.
module tb_xor3_sweep_ctrl;
  logic       clk = 1'b0;
  logic       rst, start, gate_y;
  logic [2:0] gate_in, first_fail_idx;
  logic       busy, done, pass, fail_valid;
  logic [3:0] err_count;

  int cyc = 0;
  int mode = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] err;
    logic [2:0] ffi;
    logic       fv;
    logic       pass;
  } exp_t;
  exp_t sb[$];

  xor3_sweep_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .gate_y(gate_y),
    .gate_in(gate_in), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_valid(fail_valid), .first_fail_idx(first_fail_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // 0 = good XOR, 1 = stuck-at-0, 2 = XNOR
  function automatic logic gate_f(int m, logic [2:0] v);
    case (m)
      0:       return ^v;
      1:       return 1'b0;
      default: return ~^v;
    endcase
  endfunction

  // output is X outside a sweep; the DUT must not look at it then
  assign gate_y = busy ? gate_f(mode, gate_in) : 1'bx;

  function automatic exp_t model(int m);
    exp_t e;
    e.err = 0; e.ffi = 0; e.fv = 0;
    for (int v = 0; v < 8; v++) begin
      logic [2:0] vv;
      vv = v[2:0];
      if (gate_f(m, vv) != (^vv)) begin
        if (!e.fv) begin e.fv = 1'b1; e.ffi = vv; end
        e.err = e.err + 1;
      end
    end
    e.pass = (e.err == 0);
    return e;
  endfunction

  task automatic wait_done(input int bound, output int when_cyc, output bit ok);
    ok = 0; when_cyc = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin ok = 1; when_cyc = cyc; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({gate_in, busy, done, pass, err_count, fail_valid, first_fail_idx} !== 15'd0) begin
      errors++; $display("FAIL reset_state: got %b want 0",
        {gate_in, busy, done, pass, err_count, fail_valid, first_fail_idx});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_sweeps();
    for (int m = 0; m < 3; m++) begin
      int s, w, bad;
      bit ok;
      exp_t e;
      mode = m;
      sb.push_back(model(m));
      @(negedge clk); start = 1'b1; s = cyc + 1;
      @(negedge clk); start = 1'b0;
      bad = 0;
      for (int k = 1; k < 24; k++) begin
        @(negedge clk);
        if (gate_in !== 3'(k / 3) || busy !== 1'b1 || done !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL sweep%0d_steps: got %0d bad cycles want 0", m, bad); end
      wait_done(10, w, ok);
      checks++;
      if (!ok || w - s != 24) begin errors++; $display("FAIL sweep%0d_latency: got ok=%0d lat=%0d want 24", m, ok, w - s); end
      e = sb.pop_front();
      checks++;
      if ({err_count, first_fail_idx, fail_valid, pass} !== {e.err, e.ffi, e.fv, e.pass}) begin
        errors++; $display("FAIL sweep%0d_result: got err=%0d ffi=%0d fv=%b pass=%b want err=%0d ffi=%0d fv=%b pass=%b",
          m, err_count, first_fail_idx, fail_valid, pass, e.err, e.ffi, e.fv, e.pass);
      end
      checks++;
      if (busy !== 1'b0 || gate_in !== 3'd7) begin errors++; $display("FAIL sweep%0d_end: got busy=%b gate_in=%0d want 0/7", m, busy, gate_in); end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || err_count !== e.err) begin errors++; $display("FAIL sweep%0d_hold: got done=%b err=%0d want 0/%0d", m, done, err_count, e.err); end
    end
  endtask

  task automatic test_busy_start();
    int s, w, n;
    bit ok;
    exp_t e;
    mode = 0;
    sb.push_back(model(0));
    @(negedge clk); start = 1'b1; s = cyc + 1;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    checks++;
    if (gate_in !== 3'd3) begin errors++; $display("FAIL busy_vec: got %0d want 3", gate_in); end
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done(30, w, ok);
    checks++;
    if (!ok || w - s != 24) begin errors++; $display("FAIL busy_latency: got ok=%0d lat=%0d want 24", ok, w - s); end
    e = sb.pop_front();
    checks++;
    if ({err_count, fail_valid, pass} !== {e.err, e.fv, e.pass}) begin
      errors++; $display("FAIL busy_result: got err=%0d fv=%b pass=%b want %0d/%b/%b", err_count, fail_valid, pass, e.err, e.fv, e.pass);
    end
    n = 0;
    repeat (30) begin @(negedge clk); if (done === 1'b1 || busy === 1'b1) n++; end
    checks++;
    if (n != 0) begin errors++; $display("FAIL busy_extra: got %0d active cycles want 0", n); end
  endtask

  task automatic test_reset_abort();
    int s, w, n;
    bit ok;
    exp_t e;
    mode = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({gate_in, busy, done, pass, err_count, fail_valid, first_fail_idx} !== 15'd0) begin
      errors++; $display("FAIL abort_state: got %b want 0",
        {gate_in, busy, done, pass, err_count, fail_valid, first_fail_idx});
    end
    rst = 1'b0;
    n = 0;
    repeat (30) begin @(negedge clk); if (done === 1'b1 || busy === 1'b1) n++; end
    checks++;
    if (n != 0) begin errors++; $display("FAIL abort_nodone: got %0d active cycles want 0", n); end
    sb.push_back(model(0));
    @(negedge clk); start = 1'b1; s = cyc + 1;
    @(negedge clk); start = 1'b0;
    wait_done(30, w, ok);
    checks++;
    if (!ok || w - s != 24) begin errors++; $display("FAIL abort_latency: got ok=%0d lat=%0d want 24", ok, w - s); end
    e = sb.pop_front();
    checks++;
    if ({err_count, fail_valid, pass} !== {e.err, e.fv, e.pass}) begin
      errors++; $display("FAIL abort_result: got err=%0d fv=%b pass=%b want %0d/%b/%b", err_count, fail_valid, pass, e.err, e.fv, e.pass);
    end
  endtask

  task automatic test_back_to_back();
    int s, w, prev;
    bit ok;
    exp_t e;
    mode = 2;
    sb.push_back(model(2));
    @(negedge clk); start = 1'b1; s = cyc + 1;
    wait_done(40, w, ok);
    checks++;
    if (!ok || w - s != 24) begin errors++; $display("FAIL b2b_first_latency: got ok=%0d lat=%0d want 24", ok, w - s); end
    e = sb.pop_front();
    checks++;
    if ({err_count, first_fail_idx, pass} !== {e.err, e.ffi, e.pass}) begin
      errors++; $display("FAIL b2b_first_result: got err=%0d ffi=%0d pass=%b want %0d/%0d/%b", err_count, first_fail_idx, pass, e.err, e.ffi, e.pass);
    end
    mode = 0;
    sb.push_back(model(0));
    sb.push_back(model(0));
    prev = w;
    @(negedge clk);
    checks++;
    if ({busy, done, pass, err_count, fail_valid} !== 8'b1000_0000) begin
      errors++; $display("FAIL b2b_clear: got busy=%b done=%b pass=%b err=%0d fv=%b want 1/0/0/0/0", busy, done, pass, err_count, fail_valid);
    end
    for (int r = 0; r < 2; r++) begin
      wait_done(40, w, ok);
      checks++;
      if (!ok || w - prev != 25) begin errors++; $display("FAIL b2b_period%0d: got ok=%0d period=%0d want 25", r, ok, w - prev); end
      prev = w;
      e = sb.pop_front();
      checks++;
      if ({err_count, fail_valid, pass} !== {e.err, e.fv, e.pass}) begin
        errors++; $display("FAIL b2b_result%0d: got err=%0d fv=%b pass=%b want %0d/%b/%b", r, err_count, fail_valid, pass, e.err, e.fv, e.pass);
      end
    end
    start = 1'b0;
    repeat (30) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || sb.size() != 0) begin errors++; $display("FAIL b2b_stop: got busy=%b sb=%0d want 0/0", busy, sb.size()); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    test_reset();
    test_sweeps();
    test_busy_start();
    test_reset_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
